// File: rtl/node_share_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// node_share_arb : round-robin sharing of one ST/RD handshaked node - rev 1.0
// ----------------------------------------------------------------------------
module node_share_arb #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*W-1:0] REQ_A,
  input  logic [NREQ*W-1:0] REQ_B,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   DONE,
  output logic [W-1:0]      RESULT,
  output logic              ERR,
  output logic              BUSY,
  output logic              N_ST,
  output logic [W-1:0]      N_IN0,
  output logic [W-1:0]      N_IN1,
  input  logic              N_RD,
  input  logic [W-1:0]      N_RES
);

  localparam int               IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int               CW       = 8;
  localparam logic [CW-1:0]    TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0]    LAST_RST = IW'(NREQ - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [W-1:0]    result_q, result_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            nst_q, nst_d;
  logic [W-1:0]    in0_q, in0_d;
  logic [W-1:0]    in1_q, in1_d;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            expired;

  // Scan downwards so the nearest index after last_q is the one left standing.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (REQ[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        sel_a = REQ_A[i*W +: W];
        sel_b = REQ_B[i*W +: W];
      end
    end
  end

  assign expired = (cnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    result_d = result_q;
    err_d    = 1'b0;
    nst_d    = 1'b0;
    in0_d    = in0_q;
    in1_d    = in1_q;

    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          gnt_d   = ONE_HOT0 << win_idx;
          last_d  = win_idx;
          in0_d   = sel_a;
          in1_d   = sel_b;
          nst_d   = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        cnt_d = cnt_q + 1'b1;
        if (expired) begin
          done_d   = gnt_q;
          err_d    = 1'b1;
          result_d = '0;
          state_d  = ST_RESP;
        end else if (!N_RD) begin
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        cnt_d = cnt_q + 1'b1;
        // A genuine completion on the final cycle beats the timeout.
        if (N_RD) begin
          done_d   = gnt_q;
          result_d = N_RES;
          state_d  = ST_RESP;
        end else if (expired) begin
          done_d   = gnt_q;
          err_d    = 1'b1;
          result_d = '0;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      last_q   <= LAST_RST;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      nst_q    <= 1'b0;
      in0_q    <= '0;
      in1_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      nst_q    <= nst_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
    end
  end

  assign GNT    = gnt_q;
  assign DONE   = done_q;
  assign RESULT = result_q;
  assign ERR    = err_q;
  assign BUSY   = busy_q;
  assign N_ST   = nst_q;
  assign N_IN0  = in0_q;
  assign N_IN1  = in1_q;

endmodule
`default_nettype wire
